// File: rtl/clut_pkg.sv
// Shared types and sizing for the colour look-up stage.
package clut_pkg;

  localparam int unsigned CLUT_DEPTH = 256;
  localparam int unsigned IDX_W      = $clog2(CLUT_DEPTH);
  localparam int unsigned RGB_W      = 24;
  localparam int unsigned FIFO_DEPTH = 3;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  // Occupancy counts the in-flight RAM read on top of the FIFO entries.
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 2);

  typedef logic [IDX_W-1:0] clut_index_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Circular pointer advance for a FIFO whose depth is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/clut_lookup_if.sv
// Index pixelstream: pixel plus write (valid) / strobe (consume) handshake.
interface clut_lookup_if;
  import clut_pkg::*;

  clut_index_t pixel;
  logic        write;
  logic        strobe;

  modport master (output pixel, output write, input  strobe);
  modport slave  (input  pixel, input  write, output strobe);
  modport source (output pixel, output write, input  strobe);
  modport sink   (input  pixel, input  write, output strobe);

endinterface

// File: rtl/clut_ram.sv
// 256 x 24 simple dual-port colour table; synchronous read, read-before-write.
module clut_ram
  import clut_pkg::*;
(
  input  logic        clk,
  input  logic        we_i,
  input  clut_index_t waddr_i,
  input  rgb_t        wdata_i,
  input  logic        re_i,
  input  clut_index_t raddr_i,
  output rgb_t        rdata_o
);

  rgb_t mem_q [CLUT_DEPTH];
  rgb_t rdata_q;

  // Contents are deliberately not reset; a same-edge write yields the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/clut_lookup.sv
// Colour look-up stage: index stream -> RGB888 via CPU-writable table and 3-entry FIFO.
// Optional transparency key compare enabled by defining CLUT_TRANSPARENCY_EN.
module clut_lookup
  import clut_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  clut_lookup_if.sink src,
  input  logic        clut_we,
  input  clut_index_t clut_addr,
  input  rgb_t        clut_data,
  output rgb_t        dst_rgb,
  output logic        dst_write,
  input  logic        dst_strobe,
  input  rgb_t        trans_key,
  input  logic        trans_en,
  output logic        dst_transparent
);

  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rgb_t             fifo_rgb_q [FIFO_DEPTH];
  rgb_t             ram_rdata;
  logic [OCC_W-1:0] occ_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;

  // Backpressure is a function of occupancy only, so dst_strobe never reaches src.strobe.
  assign occ_c      = OCC_W'(inflight_q) + OCC_W'(cnt_q);
  assign src.strobe = src.write && !reset && (occ_c < OCC_W'(FIFO_DEPTH));
  assign accept_c   = src.write && src.strobe;
  assign push_c     = inflight_q;
  assign pop_c      = dst_write && dst_strobe;

  clut_ram u_ram (
    .clk     (clk),
    .we_i    (clut_we),
    .waddr_i (clut_addr),
    .wdata_i (clut_data),
    .re_i    (accept_c),
    .raddr_i (src.pixel),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    inflight_d = accept_c;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push_c) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_rgb_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      if (push_c) begin
        fifo_rgb_q[wr_ptr_q] <= ram_rdata;
      end
    end
  end

  assign dst_write = (cnt_q != '0);
  assign dst_rgb   = fifo_rgb_q[rd_ptr_q];

`ifdef CLUT_TRANSPARENCY_EN
  logic fifo_tr_q [FIFO_DEPTH];
  logic push_tr_c;

  // Key compare happens on the RAM word being pushed; the flag rides in the FIFO.
  assign push_tr_c = trans_en && (ram_rdata == trans_key);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_tr_q[i] <= 1'b0;
      end
    end else if (push_c) begin
      fifo_tr_q[wr_ptr_q] <= push_tr_c;
    end
  end

  assign dst_transparent = fifo_tr_q[rd_ptr_q];
`else
  logic unused_trans;

  assign unused_trans    = ^{trans_key, trans_en};
  assign dst_transparent = 1'b0;
`endif

endmodule

// File: tb/tb_clut_lookup.sv
// Directed bench for clut_lookup with an in-order output scoreboard.
module tb_clut_lookup;
  import clut_pkg::*;

`ifdef CLUT_TRANSPARENCY_EN
  localparam bit TR_ON = 1'b1;
`else
  localparam bit TR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clut_we;
  logic [7:0]  clut_addr;
  logic [23:0] clut_data;
  logic [23:0] dst_rgb;
  logic        dst_write;
  logic        dst_strobe;
  logic [23:0] trans_key;
  logic        trans_en;
  logic        dst_transparent;

  clut_lookup_if s_if ();

  clut_lookup dut (
    .clk             (clk),
    .reset           (reset),
    .src             (s_if),
    .clut_we         (clut_we),
    .clut_addr       (clut_addr),
    .clut_data       (clut_data),
    .dst_rgb         (dst_rgb),
    .dst_write       (dst_write),
    .dst_strobe      (dst_strobe),
    .trans_key       (trans_key),
    .trans_en        (trans_en),
    .dst_transparent (dst_transparent)
  );

  always #5 clk = ~clk;

  int          n_chk   = 0;
  int          n_pass  = 0;
  int          out_cnt = 0;
  logic [23:0] model [256];
  logic [24:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_chk++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  function automatic logic [23:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5A};
  endfunction

  // Scoreboard sampled just before each rising edge: transfers on both sides.
  always @(negedge clk) begin
    #4;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (s_if.write && s_if.strobe) begin
        exp_q.push_back({TR_ON && trans_en && (model[s_if.pixel] == trans_key), model[s_if.pixel]});
      end
      if (dst_write && dst_strobe) begin
        out_cnt++;
        chk("mon_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("mon_order", 32'({dst_transparent, dst_rgb}), 32'(exp_q.pop_front()));
        end
      end
    end
    if (clut_we) model[clut_addr] = clut_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int bubbles;
    int base;
    int acc;

    for (int i = 0; i < 256; i++) model[i] = '0;
    reset = 1'b1; s_if.write = 1'b0; s_if.pixel = '0;
    clut_we = 1'b0; clut_addr = '0; clut_data = '0;
    dst_strobe = 1'b1; trans_key = 24'h123456; trans_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dst_write", 32'(dst_write), 32'd0);
    chk("rst_dst_rgb", 32'(dst_rgb), 32'd0);
    chk("rst_dst_transparent", 32'(dst_transparent), 32'd0);
    s_if.write = 1'b1; #1;
    chk("rst_src_strobe", 32'(s_if.strobe), 32'd0);
    s_if.write = 1'b0;

    // Table load: pattern everywhere, then the two named entries
    @(negedge clk);
    reset = 1'b0; clut_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      clut_addr = 8'(i); clut_data = pat(i);
      @(negedge clk);
    end
    clut_addr = 8'h05; clut_data = 24'h123456;
    @(negedge clk);
    clut_addr = 8'h7F; clut_data = 24'hABCDEF;
    @(negedge clk);
    clut_we = 1'b0;

    // Latency and back-to-back order
    s_if.write = 1'b1; s_if.pixel = 8'h05; #1;
    chk("acc_strobe", 32'(s_if.strobe), 32'd1);
    @(negedge clk);
    chk("lat_c1_write", 32'(dst_write), 32'd0);
    s_if.pixel = 8'h7F;
    @(negedge clk);
    chk("lat_c2_write", 32'(dst_write), 32'd1);
    chk("lat_c2_rgb", 32'(dst_rgb), 32'h123456);
    s_if.pixel = 8'h05;
    @(negedge clk);
    chk("lat_c3_rgb", 32'(dst_rgb), 32'hABCDEF);
    s_if.write = 1'b0;
    @(negedge clk);
    chk("lat_c4_rgb", 32'(dst_rgb), 32'h123456);
    @(negedge clk);
    chk("lat_c5_write", 32'(dst_write), 32'd0);

    // 384-pixel stream at full rate
    lows = 0; bubbles = 0; base = out_cnt;
    for (int i = 0; i < 388; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 386 && !dst_write) bubbles++;
      if (i < 384) begin
        s_if.write = 1'b1; s_if.pixel = 8'(i); #1;
        if (!s_if.strobe) lows++;
      end else begin
        s_if.write = 1'b0;
      end
    end
    chk("stream_strobe_lows", 32'(lows), 32'd0);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    chk("stream_count", 32'(out_cnt - base), 32'd384);
    chk("stream_drained", 32'(dst_write), 32'd0);

    // Stall: exactly three accepts, then resume after the first pop
    dst_strobe = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_if.write = 1'b1; s_if.pixel = 8'hA0 + 8'(acc); #1;
      if (s_if.strobe) acc++;
    end
    chk("stall_accepts", 32'(acc), 32'd3);
    @(negedge clk);
    chk("stall_strobe_low", 32'(s_if.strobe), 32'd0);
    chk("stall_write", 32'(dst_write), 32'd1);
    chk("stall_head", 32'(dst_rgb), 32'hA05FFA);
    dst_strobe = 1'b1; #1;
    chk("resume_wait", 32'(s_if.strobe), 32'd0);
    @(negedge clk);
    chk("resume_rgb1", 32'(dst_rgb), 32'hA15EFB);
    chk("resume_strobe", 32'(s_if.strobe), 32'd1);
    @(negedge clk);
    s_if.write = 1'b0;
    chk("resume_rgb2", 32'(dst_rgb), 32'hA25DF8);
    @(negedge clk);
    chk("resume_rgb3", 32'(dst_rgb), 32'hA35CF9);
    @(negedge clk);
    chk("resume_drained", 32'(dst_write), 32'd0);

    // Same-cycle CPU write and lookup of 0x05
    @(negedge clk);
    s_if.write = 1'b1; s_if.pixel = 8'h05;
    clut_we = 1'b1; clut_addr = 8'h05; clut_data = 24'hFFFFFF;
    @(negedge clk);
    clut_we = 1'b0;
    @(negedge clk);
    s_if.write = 1'b0;
    chk("rbw_old", 32'(dst_rgb), 32'h123456);
    @(negedge clk);
    chk("rbw_new", 32'(dst_rgb), 32'hFFFFFF);
    @(negedge clk);
    chk("rbw_drained", 32'(dst_write), 32'd0);

    // Reset with two FIFO entries and one in flight
    dst_strobe = 1'b0;
    @(negedge clk); s_if.write = 1'b1; s_if.pixel = 8'h10;
    @(negedge clk); s_if.pixel = 8'h11;
    @(negedge clk); s_if.pixel = 8'h12;
    @(negedge clk);
    chk("prerst_write", 32'(dst_write), 32'd1);
    chk("prerst_strobe", 32'(s_if.strobe), 32'd0);
    reset = 1'b1; s_if.write = 1'b0;
    @(negedge clk);
    chk("midrst_write", 32'(dst_write), 32'd0);
    chk("midrst_rgb", 32'(dst_rgb), 32'd0);
    s_if.write = 1'b1; #1;
    chk("midrst_strobe", 32'(s_if.strobe), 32'd0);
    reset = 1'b0; dst_strobe = 1'b1; s_if.pixel = 8'h7F; #1;
    chk("postrst_strobe", 32'(s_if.strobe), 32'd1);
    @(negedge clk);
    chk("postrst_c1_write", 32'(dst_write), 32'd0);
    s_if.pixel = 8'h05;
    @(negedge clk);
    s_if.write = 1'b0;
    chk("postrst_rgb_7f", 32'(dst_rgb), 32'hABCDEF);
    @(negedge clk);
    chk("postrst_rgb_05", 32'(dst_rgb), 32'hFFFFFF);
    @(negedge clk);
    chk("postrst_drained", 32'(dst_write), 32'd0);

    // Transparency key
    clut_we = 1'b1; clut_addr = 8'h05; clut_data = 24'h123456;
    trans_en = 1'b1; trans_key = 24'h123456;
    @(negedge clk);
    clut_we = 1'b0; s_if.write = 1'b1; s_if.pixel = 8'h05;
    @(negedge clk);
    s_if.pixel = 8'h7F;
    @(negedge clk);
    s_if.write = 1'b0;
    chk("tr_key_rgb", 32'(dst_rgb), 32'h123456);
    chk("tr_key_flag", 32'(dst_transparent), 32'(TR_ON));
    @(negedge clk);
    chk("tr_other_rgb", 32'(dst_rgb), 32'hABCDEF);
    chk("tr_other_flag", 32'(dst_transparent), 32'd0);
    @(negedge clk);
    chk("tr_gap_write", 32'(dst_write), 32'd0);
    trans_en = 1'b0; s_if.write = 1'b1; s_if.pixel = 8'h05;
    @(negedge clk);
    s_if.write = 1'b0;
    @(negedge clk);
    chk("tr_off_rgb", 32'(dst_rgb), 32'h123456);
    chk("tr_off_flag", 32'(dst_transparent), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
